// File: rtl/eigen_stage_sequencer.sv
// eigen_stage_sequencer: runs one shared find_eigen engine through NUM_EIG deflation stages.
// Optional feature macro EIG_EARLY_STOP_EN adds eig_floor and ends the run on a small eigenvalue.
module eigen_stage_sequencer #(
  parameter int NUM_EIG = 8,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 4096,
  localparam int IDX_W = $clog2(NUM_EIG) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [IDX_W-1:0]  stages_done,
  output logic              mat_sel,
  output logic              engine_start,
`ifdef EIG_EARLY_STOP_EN
  input  logic [DATA_W-1:0] eig_floor,
`endif
  input  logic              engine_done,
  input  logic [DATA_W-1:0] engine_eigenvalue,
  output logic              eig_valid,
  output logic [DATA_W-1:0] eig_value,
  output logic [IDX_W-1:0]  eig_idx
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, STORE, FINISH} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [IDX_W-1:0] stage;
  logic stop, under, tmo, last;
  assign tmo = cnt == CW'(TIMEOUT_CYC - 1);
  assign last = stop || stage == IDX_W'(NUM_EIG - 1);
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign engine_start = state == LAUNCH;
  assign eig_valid = state == STORE;
`ifdef EIG_EARLY_STOP_EN
  logic [DATA_W-1:0] mag;
  assign mag = !engine_eigenvalue[DATA_W-1] ? engine_eigenvalue :
               engine_eigenvalue[DATA_W-2:0] == '0 ? {1'b0, {(DATA_W-1){1'b1}}} : -engine_eigenvalue;
  assign under = mag < eig_floor;
`else
  assign under = 1'b0;
`endif
  // state register; async reset drops engine_start and all pulses immediately
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // next-state: engine_done beats the timeout when both land in the same cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LAUNCH : IDLE;
      LAUNCH:  nxt = WAIT;
      WAIT:    nxt = engine_done ? STORE : tmo ? FINISH : WAIT;
      STORE:   nxt = last ? FINISH : LAUNCH;
      default: nxt = IDLE;
    endcase
  end
  // stage bookkeeping, wait counter and result capture
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      stage <= '0;
      stop <= 1'b0;
      err_timeout <= 1'b0;
      stages_done <= '0;
      mat_sel <= 1'b0;
      eig_value <= '0;
      eig_idx <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          err_timeout <= 1'b0;
          stages_done <= '0;
          stage <= '0;
          mat_sel <= 1'b0;
          stop <= 1'b0;
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (engine_done) begin
            eig_value <= engine_eigenvalue;
            eig_idx <= stage;
            stop <= under;
          end else if (tmo) err_timeout <= 1'b1;
        end
        STORE: begin
          stages_done <= stages_done == IDX_W'(NUM_EIG) ? stages_done : stages_done + 1'b1;
          mat_sel <= 1'b1;
          if (!last) stage <= stage + 1'b1;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_eigen_stage_sequencer.sv
// tb_eigen_stage_sequencer: directed runs with an engine model and an eigenvalue scoreboard.
module tb_eigen_stage_sequencer;
  localparam int NE = 8, DW = 32, TO = 16, IW = 4;
  logic clk = 0, rst = 0, start = 0;
  logic busy, done, err_timeout, mat_sel, engine_start, engine_done, eig_valid;
  logic [IW-1:0] stages_done, eig_idx;
  logic [DW-1:0] engine_eigenvalue, eig_value;
  logic m_done = 0, s_done = 0;
  logic [DW-1:0] m_val = 0, s_val = 0;
`ifdef EIG_EARLY_STOP_EN
  logic [DW-1:0] eig_floor = 0;
`endif
  typedef struct packed { logic [IW-1:0] idx; logic [DW-1:0] val; } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, nvalid = 0, ndone = 0, nes = 0;
  int last_v = 0, last_es = 0, done_cyc = 0;
  int lat = 10, mute = 99, eng_n = 0;
  int vals [8];
  assign engine_done = m_done | s_done;
  assign engine_eigenvalue = s_done ? s_val : m_val;

  eigen_stage_sequencer #(.NUM_EIG(NE), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .stages_done(stages_done), .mat_sel(mat_sel),
    .engine_start(engine_start),
`ifdef EIG_EARLY_STOP_EN
    .eig_floor(eig_floor),
`endif
    .engine_done(engine_done), .engine_eigenvalue(engine_eigenvalue),
    .eig_valid(eig_valid), .eig_value(eig_value), .eig_idx(eig_idx));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // engine model: answers lat cycles into WAIT with vals[n], except stage mute
  initial begin : model
    int n;
    forever begin
      @(posedge clk); #1;
      if (engine_start) begin
        n = eng_n;
        eng_n++;
        if (n != mute && n < 8) begin
          repeat (lat) @(posedge clk);
          #1 m_val = vals[n]; m_done = 1;
          @(posedge clk); #1 m_done = 0;
        end
      end
    end
  end

  // scoreboard and event monitor
  always @(negedge clk)
    if (rst) begin
      if (eig_valid) begin
        if (q.size() == 0) chk("eig_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("eig_idx", 64'(eig_idx), 64'(e.idx));
          chk("eig_value", 64'(eig_value), 64'(e.val));
          chk("mat_sel_store", 64'(mat_sel), 64'(e.idx != 0));
        end
        nvalid++;
        last_v = cyc;
      end
      if (engine_start) begin
        nes++;
        last_es = cyc;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk("busy_at_done", 64'(busy), 1);
      end
    end

  task automatic push_run(input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.idx = IW'(i);
      x.val = DW'(vals[i]);
      q.push_back(x);
    end
  endtask

  task automatic go();
    eng_n = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int n0, k;
    n0 = ndone;
    k = 0;
    while (ndone == n0 && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    chk("done_seen", 64'(ndone - n0), 1);
    if (poke) start = 1;
    @(negedge clk); start = 0; #2;
    chk("busy_after_done", 64'(busy), 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int nv0, nd0, ne0, k;
    for (int i = 0; i < 8; i++) vals[i] = 800 - 100 * i;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_pulses", 64'({done, engine_start, eig_valid}), 0);
    chk("rst_err", 64'(err_timeout), 0);
    chk("rst_regs", 64'({stages_done, mat_sel, eig_idx}), 0);
    chk("rst_value", 64'(eig_value), 0);
    rst = 1;
    // full run, start also pulsed in WAIT and in FINISH
    nv0 = nvalid; nd0 = ndone;
    push_run(8);
    go();
    repeat (4) @(negedge clk);
    start = 1;
    @(negedge clk); start = 0;
    wait_done(300, 1);
    chk("n_stages_done", 64'(stages_done), 8);
    chk("n_err", 64'(err_timeout), 0);
    chk("n_valid_cnt", 64'(nvalid - nv0), 8);
    chk("n_queue", 64'(q.size()), 0);
    chk("n_last_value", 64'(eig_value), 100);
    chk("n_last_idx", 64'(eig_idx), 7);
    chk("n_mat_sel", 64'(mat_sel), 1);
    repeat (3) @(negedge clk);
    chk("n_single_done", 64'(ndone - nd0), 1);
    // stray engine_done while idle
    nv0 = nvalid;
    @(negedge clk); s_val = 12345; s_done = 1;
    @(negedge clk); s_done = 0;
    repeat (2) @(negedge clk);
    chk("stray_valid", 64'(nvalid - nv0), 0);
    chk("stray_value", 64'(eig_value), 100);
    chk("stray_busy", 64'(busy), 0);
    // stage 3 never answers
    nv0 = nvalid;
    mute = 3;
    push_run(3);
    go();
    wait_done(300, 0);
    chk("t_err", 64'(err_timeout), 1);
    chk("t_stages_done", 64'(stages_done), 3);
    chk("t_valid_cnt", 64'(nvalid - nv0), 3);
    chk("t_queue", 64'(q.size()), 0);
    chk("t_done_gap", 64'(done_cyc - last_es), TO + 1);
    chk("t_last_idx", 64'(eig_idx), 2);
    // engine answers on the final counter value
    nv0 = nvalid;
    mute = 99; lat = TO;
    push_run(8);
    go(); #2;
    chk("x_err_cleared", 64'(err_timeout), 0);
    chk("x_stages_cleared", 64'(stages_done), 0);
    wait_done(400, 0);
    chk("x_err", 64'(err_timeout), 0);
    chk("x_stages_done", 64'(stages_done), 8);
    chk("x_valid_cnt", 64'(nvalid - nv0), 8);
    // reset in the WAIT of stage 2
    lat = 10;
    nd0 = ndone; ne0 = nes;
    push_run(2);
    go();
    k = 0;
    while (nes - ne0 < 3 && k < 100) begin
      @(negedge clk); #2;
      k++;
    end
    chk("r_stage2_launched", 64'(nes - ne0), 3);
    repeat (3) @(negedge clk);
    #1 rst = 0;
    #1 chk("r_busy", 64'(busy), 0);
    chk("r_pulses", 64'({done, engine_start, eig_valid}), 0);
    chk("r_regs", 64'({err_timeout, stages_done, mat_sel, eig_idx}), 0);
    chk("r_value", 64'(eig_value), 0);
    repeat (2) @(negedge clk);
    rst = 1;
    nv0 = nvalid;
    repeat (20) @(negedge clk);
    #2 chk("r_no_done", 64'(ndone - nd0), 0);
    chk("r_no_valid", 64'(nvalid - nv0), 0);
    chk("r_queue", 64'(q.size()), 0);
    push_run(8);
    go();
    wait_done(300, 0);
    chk("r2_stages_done", 64'(stages_done), 8);
    chk("r2_queue", 64'(q.size()), 0);
`ifdef EIG_EARLY_STOP_EN
    eig_floor = 50;
    vals[4] = -30;
    push_run(5);
    go();
    wait_done(300, 0);
    chk("e_done_gap", 64'(done_cyc - last_v), 1);
    chk("e_stages_done", 64'(stages_done), 5);
    chk("e_err", 64'(err_timeout), 0);
    chk("e_value", 64'(eig_value), 64'(32'hFFFF_FFE2));
    chk("e_idx", 64'(eig_idx), 4);
    chk("e_queue", 64'(q.size()), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
